// File: rtl/can_pkg.sv
// Shared types and constants for the CAN 2.0A frame transmitter.
package can_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_BUS,
    ST_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK_SLOT,
    ST_ACK_DEL,
    ST_EOF,
    ST_IFS
  } can_state_e;

  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam int ID_BITS   = 11;
  localparam int DLC_BITS  = 4;
  localparam int CRC_BITS  = 15;
  localparam int EOF_BITS  = 7;
  localparam int IFS_BITS  = 3;
  localparam int IDLE_BITS = 11;
  localparam int ARB_BITS  = ID_BITS + 1;
  localparam int CTRL_BITS = DLC_BITS + 2;
  // id, rtr, ide, r0, dlc, payload: everything serialised ahead of the CRC
  localparam int SH_W      = ARB_BITS + CTRL_BITS + 64;

  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    if (rtr)          return 7'd0;
    if (dlc > 4'd8)   return 7'd64;
    return {dlc, 3'b000};
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 (CAN polynomial), one bit per shift enable, MSB-first feedback.
module can_crc15
  import can_pkg::*;
(
  input  logic        CLK,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic fb;
  assign fb = bit_in ^ crc[14];

  always_ff @(posedge CLK) begin
    if (clear)
      crc <= '0;
    else if (shift_en)
      crc <= {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'h0000);
  end

endmodule

// File: rtl/can_frame_tx.sv
// CAN 2.0A standard frame transmitter: request latch, bit timing, stuffing,
// CRC, arbitration-loss and ACK monitoring on RX.
module can_frame_tx
  import can_pkg::*;
#(
  parameter int BIT_CLKS  = 200,
  parameter int SAMPLE_PT = 140
)
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [10:0] tx_id,
  input  logic        tx_rtr,
  input  logic [3:0]  tx_dlc,
  input  logic [63:0] tx_data,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        done,
  output logic        ack_ok,
  output logic        arb_lost
);

  localparam int TW = $clog2(BIT_CLKS);

  can_state_e      state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [6:0]      cnt, cnt_n;
  logic [6:0]      nbits, nbits_n;
  logic [2:0]      run, run_n;
  logic            is_stuff, is_stuff_n;
  logic [3:0]      idle_cnt, idle_n;
  logic [SH_W-1:0] sh, sh_n;
  logic [14:0]     crc_sh, crc_sh_n;
  logic [14:0]     crc;
  logic            tx_n, busy_n, done_n, ready_n, ack_n, arb_n;
  logic            crc_en, crc_bit, crc_clr;

  logic            wrap, sample, accept, in_stuff, bus_idle;
  can_state_e      seq_state;
  logic [6:0]      seq_cnt;
  logic            seq_bit, seq_sh, seq_crc_ld, seq_crc_sh, seq_end;

  assign wrap     = (timer == TW'(BIT_CLKS - 1));
  assign sample   = (timer == TW'(SAMPLE_PT));
  assign accept   = tx_valid & tx_ready;
  assign bus_idle = (idle_cnt == 4'(IDLE_BITS));
  assign in_stuff = state inside {ST_SOF, ST_ARB, ST_CTRL, ST_DATA, ST_CRC};
  assign crc_clr  = RST | accept;

  can_crc15 u_crc (
    .CLK      (CLK),
    .clear    (crc_clr),
    .shift_en (crc_en),
    .bit_in   (crc_bit),
    .crc      (crc)
  );

  // Next regular (non-stuff) bit of the frame following the current one.
  always_comb begin
    seq_state  = state;
    seq_cnt    = cnt + 7'd1;
    seq_bit    = 1'b1;
    seq_sh     = 1'b0;
    seq_crc_ld = 1'b0;
    seq_crc_sh = 1'b0;
    seq_end    = 1'b0;
    unique case (state)
      ST_SOF: begin
        seq_state = ST_ARB;
        seq_cnt   = '0;
        seq_bit   = sh[SH_W-1];
        seq_sh    = 1'b1;
      end
      ST_ARB: begin
        seq_bit = sh[SH_W-1];
        seq_sh  = 1'b1;
        if (cnt == 7'(ARB_BITS - 1)) begin
          seq_state = ST_CTRL;
          seq_cnt   = '0;
        end
      end
      ST_CTRL, ST_DATA: begin
        if ((state == ST_CTRL && cnt == 7'(CTRL_BITS - 1) && nbits == 7'd0) ||
            (state == ST_DATA && cnt == nbits - 7'd1)) begin
          seq_state  = ST_CRC;
          seq_cnt    = '0;
          seq_bit    = crc[14];
          seq_crc_ld = 1'b1;
        end else begin
          seq_bit = sh[SH_W-1];
          seq_sh  = 1'b1;
          if (state == ST_CTRL && cnt == 7'(CTRL_BITS - 1)) begin
            seq_state = ST_DATA;
            seq_cnt   = '0;
          end
        end
      end
      ST_CRC: begin
        if (cnt == 7'(CRC_BITS - 1)) begin
          seq_state = ST_CRC_DEL;
          seq_cnt   = '0;
        end else begin
          seq_bit    = crc_sh[14];
          seq_crc_sh = 1'b1;
        end
      end
      ST_CRC_DEL:  seq_state = ST_ACK_SLOT;
      ST_ACK_SLOT: seq_state = ST_ACK_DEL;
      ST_ACK_DEL: begin
        seq_state = ST_EOF;
        seq_cnt   = '0;
      end
      ST_EOF: begin
        if (cnt == 7'(EOF_BITS - 1)) begin
          seq_state = ST_IFS;
          seq_cnt   = '0;
        end
      end
      ST_IFS: begin
        if (cnt == 7'(IFS_BITS - 1)) begin
          seq_state = ST_IDLE;
          seq_end   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n    = state;
    timer_n    = wrap ? '0 : timer + 1'b1;
    cnt_n      = cnt;
    nbits_n    = nbits;
    run_n      = run;
    is_stuff_n = is_stuff;
    sh_n       = sh;
    crc_sh_n   = crc_sh;
    tx_n       = TX;
    done_n     = 1'b0;
    ack_n      = ack_ok;
    arb_n      = arb_lost;
    crc_en     = 1'b0;
    crc_bit    = 1'b0;
    idle_n     = idle_cnt;
    if (sample)
      idle_n = !RX ? 4'd0 : (bus_idle ? idle_cnt : idle_cnt + 4'd1);

    unique case (state)
      ST_IDLE, ST_WAIT_BUS: begin
        tx_n = 1'b1;
        if (state == ST_IDLE && accept) begin
          sh_n    = {tx_id, tx_rtr, 2'b00, tx_dlc, tx_data};
          nbits_n = data_bits(tx_rtr, tx_dlc);
          ack_n   = 1'b0;
          arb_n   = 1'b0;
          state_n = ST_WAIT_BUS;
        end
        // SOF's leading zero leaves a zero-initialised CRC unchanged, so it is not shifted in.
        if ((state == ST_IDLE && accept && bus_idle) ||
            (state == ST_WAIT_BUS && wrap && bus_idle)) begin
          state_n    = ST_SOF;
          timer_n    = '0;
          tx_n       = 1'b0;
          cnt_n      = '0;
          run_n      = 3'd1;
          is_stuff_n = 1'b0;
        end
      end
      default: begin
        if (state == ST_ARB && sample && !is_stuff && TX && !RX) begin
          state_n = ST_IDLE;
          tx_n    = 1'b1;
          done_n  = 1'b1;
          arb_n   = 1'b1;
        end else begin
          if (state == ST_ACK_SLOT && sample)
            ack_n = ~RX;
          if (wrap) begin
            if (in_stuff && run == 3'd5) begin
              tx_n       = ~TX;
              is_stuff_n = 1'b1;
              run_n      = 3'd1;
            end else begin
              state_n    = seq_state;
              cnt_n      = seq_cnt;
              tx_n       = seq_bit;
              is_stuff_n = 1'b0;
              run_n      = (seq_bit == TX) ? run + 3'd1 : 3'd1;
              done_n     = seq_end;
              crc_en     = seq_sh;
              crc_bit    = seq_bit;
              if (seq_sh)     sh_n     = sh << 1;
              if (seq_crc_ld) crc_sh_n = {crc[13:0], 1'b0};
              if (seq_crc_sh) crc_sh_n = crc_sh << 1;
            end
          end
        end
      end
    endcase

    ready_n = (state_n == ST_IDLE);
    busy_n  = !ready_n;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      timer    <= '0;
      cnt      <= '0;
      nbits    <= '0;
      run      <= '0;
      is_stuff <= 1'b0;
      idle_cnt <= '0;
      sh       <= '0;
      crc_sh   <= '0;
      TX       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_ok   <= 1'b0;
      arb_lost <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      cnt      <= cnt_n;
      nbits    <= nbits_n;
      run      <= run_n;
      is_stuff <= is_stuff_n;
      idle_cnt <= idle_n;
      sh       <= sh_n;
      crc_sh   <= crc_sh_n;
      TX       <= tx_n;
      tx_ready <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
      ack_ok   <= ack_n;
      arb_lost <= arb_n;
    end
  end

endmodule

// File: tb/tb_can_frame_tx.sv
// Bench for can_frame_tx: frames are built from the protocol rules (CRC by
// polynomial long division, stuffing by scanning the bit list) and TX is
// checked on every cycle of every bit against that model.
module tb_can_frame_tx;

  localparam int B  = 20;
  localparam int SP = 14;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        tx_valid = 1'b0;
  logic [10:0] tx_id = '0;
  logic        tx_rtr = 1'b0;
  logic [3:0]  tx_dlc = '0;
  logic [63:0] tx_data = '0;
  logic        force_dom = 1'b0;
  logic        RX, TX, tx_ready, busy, done, ack_ok, arb_lost;

  // Bus model: wired-AND of our own drive and an optional dominant from another node.
  assign RX = TX & ~force_dom;

  can_frame_tx #(.BIT_CLKS(B), .SAMPLE_PT(SP)) dut (
    .CLK(CLK), .RST(RST), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_id(tx_id), .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data),
    .RX(RX), .TX(TX), .busy(busy), .done(done), .ack_ok(ack_ok), .arb_lost(arb_lost)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  bit mq[$];
  int n_stf;
  int ack_idx;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Remainder of M(x)*x^15 divided by x^15 + 0x4599.
  function automatic logic [14:0] crc_div(input bit m[$]);
    bit          w[$];
    logic [15:0] g;
    logic [14:0] r;
    g = 16'hC599;
    w = m;
    repeat (15) w.push_back(1'b0);
    for (int i = 0; i < m.size(); i++)
      if (w[i])
        for (int j = 0; j < 16; j++) w[i+j] = w[i+j] ^ g[15-j];
    r = '0;
    for (int j = 0; j < 15; j++) r[14-j] = w[m.size()+j];
    return r;
  endfunction

  task automatic build_frame(input logic [10:0] id, input logic rtr,
                             input logic [3:0] dlc, input logic [63:0] data);
    bit          u[$];
    int          nb, run;
    bit          last;
    logic [14:0] c;
    u.push_back(1'b0);
    for (int i = 10; i >= 0; i--) u.push_back(id[i]);
    u.push_back(rtr);
    u.push_back(1'b0);
    u.push_back(1'b0);
    for (int i = 3; i >= 0; i--) u.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 8 ? 8 : int'(dlc)) * 8);
    for (int i = 0; i < nb; i++) u.push_back(data[63-i]);
    c = crc_div(u);
    for (int i = 14; i >= 0; i--) u.push_back(c[i]);
    mq = {};
    run = 0;
    last = 1'b0;
    foreach (u[i]) begin
      mq.push_back(u[i]);
      if (run != 0 && u[i] == last) run++;
      else run = 1;
      last = u[i];
      if (run == 5) begin
        mq.push_back(~u[i]);
        last = ~u[i];
        run = 1;
      end
    end
    n_stf = mq.size();
    mq.push_back(1'b1);
    ack_idx = mq.size();
    repeat (12) mq.push_back(1'b1);
  endtask

  task automatic send(input string tag, input logic [10:0] id, input logic rtr,
                      input logic [3:0] dlc, input logic [63:0] data, input bit do_ack,
                      input int arb_bit, input int rst_bit, input bit immediate);
    int   lat, badc;
    bit   ok;
    logic gtx, gb, gd;
    build_frame(id, rtr, dlc, data);
    lat = 0;
    while (tx_ready !== 1'b1 && lat < 50) begin tick(); lat++; end
    chk({tag, "_ready"}, tx_ready, 1);
    tx_id = id; tx_rtr = rtr; tx_dlc = dlc; tx_data = data; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tx_id = 11'($urandom); tx_rtr = 1'($urandom); tx_dlc = 4'($urandom);
    tx_data = {$urandom, $urandom};
    lat = 0;
    while (TX !== 1'b0 && lat < 13*B) begin tick(); lat++; end
    n_cmp++;
    if (immediate ? (lat != 0) : (lat < 10*B || lat > 12*B)) begin
      n_bad++;
      $display("FAIL %s_sof_latency: got %0d cycles want %s", tag, lat,
               immediate ? "0" : "10..12 bit times");
    end
    if (TX !== 1'b0) return;
    for (int b = 0; b < mq.size(); b++) begin
      ok = 1'b1;
      badc = 0; gtx = 1'b0; gb = 1'b0; gd = 1'b0;
      force_dom = (do_ack && b == ack_idx) || (b == arb_bit);
      for (int c = 0; c < B; c++) begin
        if (b == rst_bit && c == 3) begin
          RST = 1'b1;
          force_dom = 1'b0;
          tick();
          chk({tag, "_rst_tx"}, TX, 1);
          chk({tag, "_rst_busy"}, busy, 0);
          chk({tag, "_rst_ready"}, tx_ready, 0);
          chk({tag, "_rst_flags"}, {done, ack_ok, arb_lost}, 0);
          RST = 1'b0;
          tick();
          chk({tag, "_post_rst_ready"}, tx_ready, 1);
          return;
        end
        if (b == arb_bit && c == SP + 1) begin
          force_dom = 1'b0;
          chk({tag, "_arb_done"}, done, 1);
          chk({tag, "_arb_lost"}, arb_lost, 1);
          chk({tag, "_arb_tx"}, TX, 1);
          chk({tag, "_arb_ready_busy"}, {tx_ready, busy}, 2'b10);
          tick();
          chk({tag, "_arb_done_once"}, done, 0);
          chk({tag, "_arb_hold"}, arb_lost, 1);
          return;
        end
        if (ok && (TX !== mq[b] || busy !== 1'b1 || done !== 1'b0 || tx_ready !== 1'b0)) begin
          ok = 1'b0; badc = c; gtx = TX; gb = busy; gd = done;
        end
        tick();
      end
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s_bit%0d: cycle %0d TX=%b busy=%b done=%b want TX=%b busy=1 done=0",
                 tag, b, badc, gtx, gb, gd, mq[b]);
      end
    end
    force_dom = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_end_ready_busy"}, {tx_ready, busy}, 2'b10);
    chk({tag, "_ack_ok"}, ack_ok, do_ack);
    chk({tag, "_arb_clear"}, arb_lost, 0);
    tick();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_ack_hold"}, ack_ok, do_ack);
  endtask

  initial begin : main
    bit          pq[$];
    logic [6:0]  head;
    repeat (3) tick();
    chk("reset_tx", TX, 1);
    chk("reset_ready", tx_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_flags", {done, ack_ok, arb_lost}, 0);
    RST = 1'b0;
    tick();
    chk("ready_after_reset", tx_ready, 1);

    pq = {1'b1};
    chk("model_crc_x15", crc_div(pq), 15'h4599);
    pq = {1'b1, 1'b0};
    chk("model_crc_x16", crc_div(pq), 15'h4EAB);
    build_frame(11'h000, 1'b0, 4'd0, 64'd0);
    chk("model_zero_stuffed_len", n_stf, 40);
    chk("model_zero_total_len", mq.size(), 53);
    build_frame(11'h7FF, 1'b0, 4'd0, 64'd0);
    for (int i = 0; i < 7; i++) head[6-i] = mq[i];
    chk("model_7ff_head", head, 7'b0111110);

    send("zero", 11'h000, 1'b0, 4'd0, 64'd0, 1'b0, -1, -1, 1'b0);
    send("f123_ack", 11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b1, -1, -1, 1'b1);
    send("f123_noack", 11'h123, 1'b0, 4'd1, 64'hAA00_0000_0000_0000, 1'b0, -1, -1, 1'b1);
    send("arb7ff", 11'h7FF, 1'b0, 4'd2, 64'h1234_5678_9ABC_DEF0, 1'b1, 3, -1, 1'b1);
    send("dlc15", 11'h2A5, 1'b0, 4'd15, {$urandom, $urandom}, 1'b1, -1, -1, 1'b0);
    send("rtr8", 11'h456, 1'b1, 4'd8, {$urandom, $urandom}, 1'b1, -1, -1, 1'b1);
    for (int i = 0; i < 8; i++)
      send($sformatf("rnd%0d", i), 11'($urandom), 1'($urandom_range(0, 3) == 0),
           4'($urandom), {$urandom, $urandom}, 1'($urandom), -1, -1, 1'b1);
    send("rst_data", 11'h3C3, 1'b0, 4'd8, {$urandom, $urandom}, 1'b1, -1, 35, 1'b1);
    send("after_rst", 11'h0F0, 1'b0, 4'd3, {$urandom, $urandom}, 1'b1, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/can_frame_tx.md
# can_frame_tx

Parameterised CAN 2.0A frame transmitter that replaces fixed timer-table TX patterns on the board test path. Accepts identifier, RTR flag, DLC and payload through a valid/ready handshake, serialises a complete standard data/remote frame with CRC-15 and bit stuffing onto TX at a fixed bit time, and monitors RX for arbitration loss and ACK. Sits between the test/command logic and the transceiver pins.

## Interface
- BIT_CLKS, 200, CLK cycles per CAN bit (≥ 8)
- SAMPLE_PT, 140, cycle index within a bit at which RX is sampled (1 ≤ SAMPLE_PT < BIT_CLKS)
- CLK  in  1  system clock; one clock domain
- RST  in  1  reset; synchronous, active-high
- tx_valid  in  1  request valid
- tx_ready  out  1  high only in IDLE
- tx_id  in  11  identifier, MSB sent first
- tx_rtr  in  1  remote frame (no data field)
- tx_dlc  in  4  DLC sent as-is; byte count = min(dlc, 8)
- tx_data  in  64  payload; [63:56] = byte 0, MSB first
- RX  in  1  bus level from transceiver (already synchronised)
- TX  out  1  bus drive, 1 = recessive
- busy  out  1  frame in progress (not IDLE)
- done  out  1  one-cycle pulse at end of attempt
- ack_ok  out  1  valid with done: ACK slot sampled dominant
- arb_lost  out  1  valid with done: arbitration lost

## Operation
- Request accepted on tx_valid & tx_ready; all inputs latched that cycle.
- Bus-idle counter: counts consecutive recessive RX samples, saturates at 11, clears on any dominant sample; runs in every state.
- States: IDLE → WAIT_BUS (until idle count = 11) → SOF → ARB (11 ID bits + RTR) → CTRL (IDE=0, r0=0, DLC 4) → DATA (8·n bits, skipped if RTR or n=0) → CRC (15) → CRC_DEL → ACK_SLOT → ACK_DEL → EOF (7) → IFS (3) → IDLE.
- CRC-15: poly 0x4599, init 0, over unstuffed bits SOF through last data bit; sent MSB first.
- Stuffing: SOF through last CRC bit; after 5 identical consecutive transmitted bits (stuff bits included in the run) insert the complement; stuff bits not CRC'd. A stuff bit due after the last CRC bit is inserted. No stuffing from CRC_DEL onward.
- ACK_SLOT: TX recessive; RX sample at SAMPLE_PT latched into ack_ok.
- Arbitration: in ARB (not stuff bits), TX recessive but RX sampled dominant → TX recessive from next cycle, arb_lost=1, done pulse, return to IDLE. No automatic retry.
- RX mismatches outside ARB/ACK_SLOT ignored (no error frames).
- RST mid-frame: next cycle TX=1, state IDLE, all outputs at reset values; idle counter cleared.

## Timing
- Reset values: TX=1, tx_ready=0 during RST then 1 first cycle after, busy=0, done=0, ack_ok=0, arb_lost=0.
- Bit timer 0..BIT_CLKS-1; TX updates only when timer wraps to 0; exactly BIT_CLKS cycles per bit.
- If idle count already 11 at acceptance, SOF (TX=0) appears the cycle after acceptance; otherwise at next bit boundary after count reaches 11.
- done asserts the cycle after the last IFS bit ends (or after arb_lost detection); tx_ready=1 that same cycle. ack_ok/arb_lost hold until next acceptance.
- All outputs registered.

## Structure
- can_pkg: state enum, CRC_POLY=15'h4599, field lengths (ID 11, DLC 4, CRC 15, EOF 7, IFS 3, IDLE_BITS 11).
- Sub-module can_crc15: serial CRC-15, ports clear, shift enable, bit in, 15-bit crc out.
- Top holds FSM, bit timer, field bit counter, stuff run counter, idle counter.

## Test plan
- id=0x000, rtr=0, dlc=0, RX=TX loopback after 11 idle bits: SOF..CRC = 34 zeros, stuff bit 1 after every 5th zero (6 inserted), 40 bits total before CRC_DEL; each bit exactly 200 cycles.
- id=0x123, dlc=1, data byte 0xAA, RX forced 0 during ACK_SLOT: decoded frame matches bit-accurate model incl. CRC; done pulses once, ack_ok=1, arb_lost=0.
- Same frame, RX follows TX (no ACK): ack_ok=0, frame otherwise identical.
- id=0x7FF, RX forced 0 at 3rd ID bit: TX recessive from following cycle, arb_lost=1, done one cycle, tx_ready=1.
- dlc=15, rtr=0: DLC field sends 1111, exactly 64 data bits; rtr=1, dlc=8: no data field.
- RST asserted mid-DATA: TX=1 next cycle, busy=0; new request waits 11 recessive bits before SOF.
